// File: rtl/gray_conv_arbiter_if.sv
// Handshake bundle for gray_conv_arbiter: two Gray-coded requesters (A, B)
// on the input side and one binary result channel on the output side.
// The master modport is the environment side; slave is the arbiter.
interface gray_conv_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_gray;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_gray;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_bin;
  logic [WIDTH-1:0] out_gray;
  logic             out_id;
  logic             out_err;
  logic             out_ready;
  logic             busy;

  modport master (
    output a_valid, a_gray, b_valid, b_gray, out_ready,
    input  a_ready, b_ready, out_valid, out_bin, out_gray, out_id, out_err, busy
  );

  modport slave (
    input  a_valid, a_gray, b_valid, b_gray, out_ready,
    output a_ready, b_ready, out_valid, out_bin, out_gray, out_id, out_err, busy
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter in front of one registered Gray-to-binary stage.
// Two requesters share the converter; the one-word result register can be
// drained and refilled in the same cycle, so throughput is one word/cycle.
// Optional feature macro: GRAY_CONV_STEP_CHECK_EN enables per-requester
// step checking (out_err flags any code change that is not a single bit).
module gray_conv_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  gray_conv_arbiter_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic             last_id;
  logic             grant_valid;
  logic             grant_id;
  logic [WIDTH-1:0] grant_gray;
  logic [WIDTH-1:0] grant_bin;
  logic             can_accept;
  logic             accept;
  logic             drain;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             id_q;

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Arbitration, accept/drain decisions and EMPTY/FULL next state.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    grant_gray  = bus.a_gray;
    state_next  = state;
    if (bus.a_valid && bus.b_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_id;
    end else if (bus.a_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (bus.b_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
    if (grant_id) begin
      grant_gray = bus.b_gray;
    end
    // rst_n gating keeps both readies low for the whole reset interval
    can_accept = rst_n && ena && ((state == EMPTY) || bus.out_ready);
    accept     = can_accept && grant_valid;
    drain      = (state == FULL) && bus.out_ready;
    case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL:  if (drain && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  assign grant_bin = gray2bin(grant_gray);

  // EMPTY/FULL state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Result register and round-robin pointer; both move only on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      gray_q  <= '0;
      id_q    <= 1'b0;
      last_id <= 1'b1;
    end else if (accept) begin
      bin_q   <= grant_bin;
      gray_q  <= grant_gray;
      id_q    <= grant_id;
      last_id <= grant_id;
    end
  end

`ifdef GRAY_CONV_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_gray_a;
  logic [WIDTH-1:0] prev_gray_b;
  logic             prev_seen_a;
  logic             prev_seen_b;
  logic             grant_err;
  logic             err_q;
  logic [WIDTH-1:0] step_diff;

  // A legal step changes exactly one bit against that requester's last word.
  always_comb begin
    step_diff = grant_id ? (grant_gray ^ prev_gray_b) : (grant_gray ^ prev_gray_a);
    grant_err = (grant_id ? prev_seen_b : prev_seen_a) &&
                !((step_diff != '0) && ((step_diff & (step_diff - ONE)) == '0));
  end

  // Per-requester history, so interleaving never mixes the two streams.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray_a <= '0;
      prev_gray_b <= '0;
      prev_seen_a <= 1'b0;
      prev_seen_b <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept) begin
      err_q <= grant_err;
      if (grant_id) begin
        prev_gray_b <= grant_gray;
        prev_seen_b <= 1'b1;
      end else begin
        prev_gray_a <= grant_gray;
        prev_seen_a <= 1'b1;
      end
    end
  end

  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.a_ready   = accept && !grant_id;
  assign bus.b_ready   = accept && grant_id;
  assign bus.out_valid = (state == FULL);
  assign bus.busy      = (state == FULL);
  assign bus.out_bin   = bin_q;
  assign bus.out_gray  = gray_q;
  assign bus.out_id    = id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: directed stimulus pushes the
// hand-computed result for every word it expects to emerge, and an
// independent monitor pops and compares on each out_valid & out_ready.
module tb_gray_conv_arbiter;

`ifdef GRAY_CONV_STEP_CHECK_EN
  localparam logic STEP = 1'b1;
`else
  localparam logic STEP = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] bin;
    logic [7:0] gray;
    logic       id;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  logic ena;
  int   checks;
  int   failures;
  exp_t sb[$];

  gray_conv_arbiter_if #(.WIDTH(8)) bus ();

  gray_conv_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus.slave)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic av, input logic [7:0] ag,
                                input logic bv, input logic [7:0] bg);
    bus.a_valid = av;
    bus.a_gray  = ag;
    bus.b_valid = bv;
    bus.b_gray  = bg;
  endtask

  task automatic push(input logic [7:0] bin, input logic [7:0] gray,
                      input logic id, input logic err);
    exp_t e;
    e.bin  = bin;
    e.gray = gray;
    e.id   = id;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Offer a single word from one requester for one cycle and expect it out.
  task automatic send_one(input logic id, input logic [7:0] gray,
                          input logic [7:0] bin, input logic err);
    if (id) apply_stimulus(1'b0, 8'h00, 1'b1, gray);
    else    apply_stimulus(1'b1, gray, 1'b0, 8'h00);
    push(bin, gray, id, err);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    bus.out_ready = 1'b0;
    ena = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: every transferred result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output: got bin=0x%0h id=%0d, expected none",
                 bus.out_bin, bus.out_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("out_bin",  32'(bus.out_bin),  32'(e.bin));
        check_output("out_gray", 32'(bus.out_gray), 32'(e.gray));
        check_output("out_id",   32'(bus.out_id),   32'(e.id));
        check_output("out_err",  32'(bus.out_err),  32'(e.err));
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    ena      = 1'b1;
    bus.out_ready = 1'b1;
    apply_stimulus(1'b1, 8'h06, 1'b1, 8'h05);

    // Reset state, readies held low even with requests pending
    neg();
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_out_bin",   32'(bus.out_bin),   32'd0);
    check_output("rst_out_gray",  32'(bus.out_gray),  32'd0);
    check_output("rst_out_id",    32'(bus.out_id),    32'd0);
    check_output("rst_out_err",   32'(bus.out_err),   32'd0);
    check_output("rst_busy",      32'(bus.busy),      32'd0);
    check_output("rst_a_ready",   32'(bus.a_ready),   32'd0);
    check_output("rst_b_ready",   32'(bus.b_ready),   32'd0);
    tick();
    rst_n = 1'b1;

    // Single word from A: 0x06 -> 0x04, one-cycle latency
    apply_stimulus(1'b1, 8'h06, 1'b0, 8'h00);
    push(8'h04, 8'h06, 1'b0, 1'b0);
    neg();
    check_output("t1_a_ready", 32'(bus.a_ready), 32'd1);
    check_output("t1_b_ready", 32'(bus.b_ready), 32'd0);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    neg();
    check_output("t1_out_valid", 32'(bus.out_valid), 32'd1);
    check_output("t1_busy",      32'(bus.busy),      32'd1);
    tick();
    neg();
    check_output("t1_out_valid_drop", 32'(bus.out_valid), 32'd0);

    // Tie for four accepts alternates A,B,A,B; repeats flag with step check
    do_reset();
    bus.out_ready = 1'b1;
    apply_stimulus(1'b1, 8'h80, 1'b1, 8'h01);
    push(8'hFF, 8'h80, 1'b0, 1'b0);
    push(8'h01, 8'h01, 1'b1, 1'b0);
    push(8'hFF, 8'h80, 1'b0, STEP);
    push(8'h01, 8'h01, 1'b1, STEP);
    repeat (4) tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    neg();
    check_output("t2_out_valid_drop", 32'(bus.out_valid), 32'd0);

    // Stall: held result stays stable, readies low; then drain+refill
    do_reset();
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, 8'h02, 1'b0, 8'h00);
    push(8'h03, 8'h02, 1'b0, 1'b0);
    neg();
    check_output("t3_a_ready", 32'(bus.a_ready), 32'd1);
    tick();
    apply_stimulus(1'b1, 8'h06, 1'b1, 8'h05);
    push(8'h06, 8'h05, 1'b1, 1'b0);
    push(8'h04, 8'h06, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      neg();
      check_output("t3_hold_a_ready", 32'(bus.a_ready),   32'd0);
      check_output("t3_hold_b_ready", 32'(bus.b_ready),   32'd0);
      check_output("t3_hold_valid",   32'(bus.out_valid), 32'd1);
      check_output("t3_hold_bin",     32'(bus.out_bin),   32'h03);
      check_output("t3_hold_gray",    32'(bus.out_gray),  32'h02);
      check_output("t3_hold_id",      32'(bus.out_id),    32'd0);
    end
    tick();
    bus.out_ready = 1'b1;
    neg();
    check_output("t3_refill_b_ready", 32'(bus.b_ready), 32'd1);
    check_output("t3_refill_a_ready", 32'(bus.a_ready), 32'd0);
    tick();
    apply_stimulus(1'b1, 8'h06, 1'b0, 8'h00);
    neg();
    check_output("t3_refill_valid", 32'(bus.out_valid), 32'd1);
    check_output("t3_refill_id",    32'(bus.out_id),    32'd1);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    neg();
    check_output("t3_out_valid_drop", 32'(bus.out_valid), 32'd0);

    // ena low: no accepts, but the held result still drains
    do_reset();
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, 8'h01, 1'b0, 8'h00);
    push(8'h01, 8'h01, 1'b0, 1'b0);
    tick();
    ena = 1'b0;
    apply_stimulus(1'b1, 8'h03, 1'b1, 8'h07);
    for (int i = 0; i < 2; i++) begin
      neg();
      check_output("t4_a_ready", 32'(bus.a_ready),   32'd0);
      check_output("t4_b_ready", 32'(bus.b_ready),   32'd0);
      check_output("t4_valid",   32'(bus.out_valid), 32'd1);
    end
    tick();
    bus.out_ready = 1'b1;
    neg();
    check_output("t4_drain_a_ready", 32'(bus.a_ready), 32'd0);
    check_output("t4_drain_b_ready", 32'(bus.b_ready), 32'd0);
    tick();
    neg();
    check_output("t4_after_drain_valid",   32'(bus.out_valid), 32'd0);
    check_output("t4_after_drain_a_ready", 32'(bus.a_ready),   32'd0);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    ena = 1'b1;

    // Asynchronous reset while FULL discards the result (nothing pushed)
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, 8'h04, 1'b0, 8'h00);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    neg();
    check_output("t5_full_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t5_async_valid", 32'(bus.out_valid), 32'd0);
    check_output("t5_async_busy",  32'(bus.busy),      32'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    apply_stimulus(1'b1, 8'h10, 1'b1, 8'h20);
    push(8'h1F, 8'h10, 1'b0, 1'b0);
    push(8'h3F, 8'h20, 1'b1, 1'b0);
    neg();
    check_output("t5_tie_a_ready", 32'(bus.a_ready), 32'd1);
    check_output("t5_tie_b_ready", 32'(bus.b_ready), 32'd0);
    tick();
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    tick();

    // Step-check sequences: A 00,01,03,00 then interleaved B 00,03 and A 01
    do_reset();
    bus.out_ready = 1'b1;
    send_one(1'b0, 8'h00, 8'h00, 1'b0);
    send_one(1'b0, 8'h01, 8'h01, 1'b0);
    send_one(1'b0, 8'h03, 8'h02, 1'b0);
    send_one(1'b0, 8'h00, 8'h00, STEP);
    send_one(1'b1, 8'h00, 8'h00, 1'b0);
    send_one(1'b0, 8'h01, 8'h01, 1'b0);
    send_one(1'b1, 8'h03, 8'h02, STEP);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    repeat (3) tick();

    check_output("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish before limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
